// File: rtl/luffa_io_if.sv
// luffa_io_if: device-side responder for the 16-bit init/load/fetch/ack host
// protocol in front of the Luffa-256 compression/finalization core.
//
// Host side:
//   init           - start a new message (level, sampled every cycle)
//   load/idata     - one message word per request
//   fetch/odata    - one digest word per request
//   ack            - one-cycle pulse: word accepted or odata valid
//   err            - sticky protocol error, cleared by init or reset
// Core side:
//   core_init      - one-cycle pulse: reset chaining state
//   core_blk/_valid/_ready - 256-bit block handshake, first word in MSBs
//   core_final     - one-cycle pulse: run finalization
//   core_dig/_valid - digest return, word 0 in MSBs
module luffa_io_if #(
    parameter int IOSIZE      = 16,
    parameter int BLOCK_BITS  = 256,
    parameter int DIGEST_BITS = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init,
    input  logic                   load,
    input  logic                   fetch,
    input  logic [IOSIZE-1:0]      idata,
    output logic                   ack,
    output logic [IOSIZE-1:0]      odata,
    output logic                   err,
    output logic                   core_init,
    output logic [BLOCK_BITS-1:0]  core_blk,
    output logic                   core_blk_valid,
    input  logic                   core_blk_ready,
    output logic                   core_final,
    input  logic [DIGEST_BITS-1:0] core_dig,
    input  logic                   core_dig_valid
);

    localparam int WPB = BLOCK_BITS / IOSIZE;
    localparam int WPD = DIGEST_BITS / IOSIZE;
    localparam int WRW = $clog2(WPB);
    localparam int RRW = $clog2(WPD);

    localparam logic [WRW-1:0] WCNT_ONE  = WRW'(1);
    localparam logic [WRW-1:0] WCNT_LAST = WRW'(WPB - 1);
    localparam logic [RRW-1:0] RPTR_ONE  = RRW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HANDOFF,
        ST_FINAL_WAIT,
        ST_OUT
    } state_t;

    state_t                   state_q;
    logic [WRW-1:0]           wcnt_q;
    logic [RRW-1:0]           rptr_q;
    logic [BLOCK_BITS-1:0]    buf_q;
    logic [BLOCK_BITS-1:0]    buf_d;
    logic [DIGEST_BITS-1:0]   dig_q;
    logic                     dig_valid_q;
    logic                     ack_q;
    logic [IOSIZE-1:0]        odata_q;
    logic                     err_q;
    logic                     core_init_q;
    logic                     core_blk_valid_q;
    logic                     core_final_q;
    logic [IOSIZE-1:0]        dig_word;

    // Words enter at the bottom and move up, so the first word ends in the MSBs.
    always_comb begin
        buf_d = {buf_q[BLOCK_BITS-IOSIZE-1:0], idata};
    end

    // Digest word selected by rptr; word 0 lives in the MSBs.
    always_comb begin
        dig_word = '0;
        for (int unsigned i = 0; i < WPD; i++) begin
            if (rptr_q == i[RRW-1:0]) begin
                dig_word = dig_q[(WPD-1-i)*IOSIZE +: IOSIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            wcnt_q           <= '0;
            rptr_q           <= '0;
            buf_q            <= '0;
            dig_q            <= '0;
            dig_valid_q      <= 1'b0;
            ack_q            <= 1'b0;
            odata_q          <= '0;
            err_q            <= 1'b0;
            core_init_q      <= 1'b0;
            core_blk_valid_q <= 1'b0;
            core_final_q     <= 1'b0;
        end else if (init) begin
            state_q          <= ST_IDLE;
            wcnt_q           <= '0;
            rptr_q           <= '0;
            buf_q            <= '0;
            dig_valid_q      <= 1'b0;
            ack_q            <= 1'b0;
            err_q            <= 1'b0;
            core_init_q      <= 1'b1;
            core_blk_valid_q <= 1'b0;
            core_final_q     <= 1'b0;
        end else begin
            ack_q        <= 1'b0;
            core_init_q  <= 1'b0;
            core_final_q <= 1'b0;

            unique case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (fetch && !ack_q) begin
                        if (wcnt_q != '0) begin
                            err_q <= 1'b1;
                        end else if (!dig_valid_q) begin
                            core_final_q <= 1'b1;
                            state_q      <= ST_FINAL_WAIT;
                        end else begin
                            odata_q <= dig_word;
                            ack_q   <= 1'b1;
                            rptr_q  <= rptr_q + RPTR_ONE;
                            state_q <= ST_OUT;
                        end
                    end else if (load && !ack_q) begin
                        buf_q  <= buf_d;
                        wcnt_q <= wcnt_q + WCNT_ONE;
                        ack_q  <= 1'b1;
                        if (wcnt_q == WCNT_LAST) begin
                            // Counter wraps to 0 here; block is complete.
                            core_blk_valid_q <= 1'b1;
                            state_q          <= ST_HANDOFF;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end

                ST_HANDOFF: begin
                    // Loads stall here; buf_q is frozen so core_blk stays stable.
                    if (core_blk_ready) begin
                        core_blk_valid_q <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                end

                ST_FINAL_WAIT: begin
                    if (core_dig_valid) begin
                        dig_q       <= core_dig;
                        dig_valid_q <= 1'b1;
                        odata_q     <= core_dig[DIGEST_BITS-1 -: IOSIZE];
                        ack_q       <= 1'b1;
                        rptr_q      <= RPTR_ONE;
                        state_q     <= ST_OUT;
                    end else if (load && !ack_q) begin
                        err_q <= 1'b1;
                    end
                end

                ST_OUT: begin
                    if (fetch && !ack_q) begin
                        odata_q <= dig_word;
                        ack_q   <= 1'b1;
                        rptr_q  <= rptr_q + RPTR_ONE;
                    end else if (load && !ack_q) begin
                        err_q <= 1'b1;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack            = ack_q;
    assign odata          = odata_q;
    assign err            = err_q;
    assign core_init      = core_init_q;
    assign core_blk       = buf_q;
    assign core_blk_valid = core_blk_valid_q;
    assign core_final     = core_final_q;

endmodule

// File: tb/tb_luffa_io_if.sv
module tb_luffa_io_if;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init = 1'b0;
    logic         load = 1'b0;
    logic         fetch = 1'b0;
    logic [15:0]  idata = '0;
    logic         ack;
    logic [15:0]  odata;
    logic         err;
    logic         core_init;
    logic [255:0] core_blk;
    logic         core_blk_valid;
    logic         core_blk_ready = 1'b1;
    logic         core_final;
    logic [255:0] core_dig = '0;
    logic         core_dig_valid = 1'b0;

    luffa_io_if #(
        .IOSIZE(16),
        .BLOCK_BITS(256),
        .DIGEST_BITS(256)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .init(init),
        .load(load),
        .fetch(fetch),
        .idata(idata),
        .ack(ack),
        .odata(odata),
        .err(err),
        .core_init(core_init),
        .core_blk(core_blk),
        .core_blk_valid(core_blk_valid),
        .core_blk_ready(core_blk_ready),
        .core_final(core_final),
        .core_dig(core_dig),
        .core_dig_valid(core_dig_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_fetch;
        logic [15:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] blk_q[$];
    int           checks = 0;
    int           errors = 0;
    int           init_cnt = 0;
    int           final_cnt = 0;
    logic [255:0] DIG;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT acks or offers a block.
    initial begin
        exp_t e;
        logic prev_ack = 1'b0;
        logic prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack) begin
                    check("ack_spacing", {255'b0, prev_ack}, 256'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack actual=1 required=0");
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_fetch) check("odata", {240'b0, odata}, {240'b0, e.data});
                    end
                end
                if (core_blk_valid && !prev_valid) begin
                    if (blk_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_block actual=%0h required=none", core_blk);
                    end else begin
                        check("core_blk", core_blk, blk_q.pop_front());
                    end
                end
                if (core_init) init_cnt++;
            end
            prev_ack   = ack;
            prev_valid = core_blk_valid;
        end
    end

    // Core model: returns the fixed digest 20 cycles after each core_final.
    initial begin
        forever begin
            @(negedge clk);
            if (core_final) begin
                final_cnt++;
                repeat (19) @(negedge clk);
                core_dig       = DIG;
                core_dig_valid = 1'b1;
                @(negedge clk);
                core_dig_valid = 1'b0;
            end
        end
    end

    task automatic wait_ack(input string name);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ack) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=no_ack required=ack", name);
    endtask

    task automatic load_word(input logic [15:0] w);
        exp_q.push_back('{1'b0, w});
        idata = w;
        load  = 1'b1;
        wait_ack("load");
    endtask

    task automatic fetch_word(input logic [15:0] w);
        exp_q.push_back('{1'b1, w});
        fetch = 1'b1;
        wait_ack("fetch");
        fetch = 1'b0;
    endtask

    task automatic do_init();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] blk;
        int f0;
        int i0;

        for (int i = 0; i < 16; i++) DIG[255-16*i -: 16] = 16'hA000 + 16'(i);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", {255'b0, ack}, 256'd0);
        check("rst_odata", {240'b0, odata}, 256'd0);
        check("rst_err", {255'b0, err}, 256'd0);
        check("rst_blk_valid", {255'b0, core_blk_valid}, 256'd0);
        check("rst_core_init", {255'b0, core_init}, 256'd0);
        check("rst_core_final", {255'b0, core_final}, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // One block with load held, then a 5-cycle ready stall
        for (int i = 0; i < 16; i++) blk[255-16*i -: 16] = 16'(i + 1);
        blk_q.push_back(blk);
        core_blk_ready = 1'b0;
        for (int i = 1; i <= 16; i++) load_word(16'(i));
        idata = 16'h1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_blk", core_blk, blk);
            check("stall_valid", {255'b0, core_blk_valid}, 256'd1);
            check("stall_ack", {255'b0, ack}, 256'd0);
        end
        load = 1'b0;
        core_blk_ready = 1'b1;
        @(negedge clk);
        check("handoff_drop", {255'b0, core_blk_valid}, 256'd0);

        // Digest readout with wrap on the 17th fetch
        f0 = final_cnt;
        for (int i = 0; i < 16; i++) fetch_word(16'hA000 + 16'(i));
        fetch_word(16'hA000);
        check("final_pulses", 256'(final_cnt - f0), 256'd1);

        // Load while in OUT is an error with no ack
        idata = 16'h2222;
        load  = 1'b1;
        repeat (2) @(negedge clk);
        load  = 1'b0;
        check("load_in_out_err", {255'b0, err}, 256'd1);

        // Partial-block fetch error, cleared by init
        do_init();
        check("init_clears_err", {255'b0, err}, 256'd0);
        for (int i = 0; i < 3; i++) load_word(16'h0300 + 16'(i));
        load = 1'b0;
        f0 = final_cnt;
        fetch = 1'b1;
        repeat (4) @(negedge clk);
        fetch = 1'b0;
        check("partial_fetch_err", {255'b0, err}, 256'd1);
        check("partial_no_final", 256'(final_cnt - f0), 256'd0);
        i0 = init_cnt;
        do_init();
        check("err_cleared", {255'b0, err}, 256'd0);
        check("core_init_once", 256'(init_cnt - i0), 256'd1);

        // init mid-block restarts the word count
        for (int i = 0; i < 7; i++) load_word(16'h0B00 + 16'(i));
        load = 1'b0;
        do_init();
        for (int i = 0; i < 16; i++) blk[255-16*i -: 16] = 16'h0C00 + 16'(i);
        blk_q.push_back(blk);
        for (int i = 0; i < 16; i++) load_word(16'h0C00 + 16'(i));
        load = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during OUT discards the digest
        f0 = final_cnt;
        fetch_word(16'hA000);
        fetch_word(16'hA001);
        check("final_after_block", 256'(final_cnt - f0), 256'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_out_ack", {255'b0, ack}, 256'd0);
        check("rst_out_odata", {240'b0, odata}, 256'd0);
        check("rst_out_err", {255'b0, err}, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        fetch_word(16'hA000);
        check("final_after_reset", 256'(final_cnt - f0), 256'd2);

        repeat (2) @(negedge clk);
        check("queues_empty", 256'(exp_q.size() + blk_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/luffa_io_if.md
Name: luffa_io_if

Overview:
- Device-side responder for the 16-bit init/load/fetch/ack host protocol in front of the Luffa-256 hash core.
- Load path: collects 16-bit words from the host into 256-bit message blocks and hands each block to the core.
- Fetch path: on the first fetch, asks the core to finalize, then returns the 256-bit digest 16 bits per fetch.
- Sits between the top-level pins and the compression/finalization core.

Parameters:
- IOSIZE, 16, host data word width
- BLOCK_BITS, 256, message block width; WPB = BLOCK_BITS/IOSIZE = 16 words
- DIGEST_BITS, 256, digest width; WPD = DIGEST_BITS/IOSIZE = 16 words

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; synchronous and active-low
- init  in  1  host: start new message (level, sampled each cycle)
- load  in  1  host: idata holds a valid message word
- fetch  in  1  host: request next digest word
- idata  in  IOSIZE  host message word
- ack  out  1  one-cycle pulse: word accepted (load) or odata valid (fetch)
- odata  out  IOSIZE  digest word
- err  out  1  sticky protocol error
- core_init  out  1  one-cycle pulse: reset core chaining state
- core_blk  out  BLOCK_BITS  message block; first-loaded word in bits [255:240]
- core_blk_valid  out  1  block offered; held until core_blk_ready
- core_blk_ready  in  1  core accepts block when valid&ready
- core_final  out  1  one-cycle pulse: run finalization
- core_dig  in  DIGEST_BITS  digest; word 0 = bits [255:240]
- core_dig_valid  in  1  one-cycle pulse: core_dig valid

Behaviour:
- Reset (rst_n=0 at posedge):
  - ack=0, odata=0, err=0; core_init, core_blk_valid, core_final all 0.
  - Word counter wcnt=0, read pointer rptr=0, digest register cleared.
  - State IDLE.
  - Reset overrides everything, including mid-block and mid-output.
- ack is registered. A new request is acted on only in a cycle where registered ack=0, so ack pulses at most every other cycle even when load or fetch is held high. This gives the host time to change idata.
- Priority in a cycle: rst_n > init > fetch > load.
- init=1:
  - Clear wcnt, rptr, err, digest-valid flag and the block buffer.
  - Pulse core_init next cycle; drop any pending core_blk_valid.
  - State IDLE; no ack.
- States: IDLE, FILL, HANDOFF, FINAL_WAIT, OUT.
- IDLE/FILL, load=1, ack=0:
  - Shift idata into the buffer MSW-first; wcnt++; ack=1 next cycle; state FILL.
  - On the 16th word (wcnt 15->0): core_blk_valid=1 with the assembled block; state HANDOFF.
- HANDOFF:
  - Hold core_blk_valid and core_blk stable until core_blk_ready.
  - Then drop core_blk_valid and return to IDLE.
  - load in HANDOFF: no ack (stall, not an error).
- fetch=1, ack=0, state IDLE with wcnt=0 and no digest held:
  - Pulse core_final; state FINAL_WAIT.
- FINAL_WAIT:
  - On core_dig_valid, capture core_dig and set rptr=0.
  - Drive odata=word0 and ack=1 next cycle; rptr=1; state OUT.
  - fetch is ignored in this state until capture.
- OUT, fetch=1, ack=0:
  - odata = digest word[rptr]; ack=1 next cycle; rptr++, wrapping 15->0.
  - The digest is re-readable until init.
- odata holds its last value between fetches.
- Errors (set err=1, no ack, state unchanged):
  - fetch while 0<wcnt<16 (partial block).
  - load in FINAL_WAIT or OUT.
- err clears only on init or reset.
- Unused or idle combinations (load and fetch both 0) leave state unchanged.

Test Plan:
- Reset, then load 16 words 0x0001..0x0010 with load held high:
  - 16 ack pulses, each separated by ≥1 low cycle.
  - core_blk_valid rises with core_blk = 0x0001_0002_…_0010.
  - Hold core_blk_ready=0 for 5 cycles: core_blk stays stable and the next load gets no ack. Releasing ready returns the block to IDLE.
- After one block, fetch:
  - One core_final pulse.
  - Model returns core_dig 0xA000_A001…_A00F after 20 cycles.
  - 16 fetches return 0xA000..0xA00F, each with an ack pulse; the 17th fetch returns 0xA000 (wrap).
- Load 3 words, then fetch:
  - err=1, no ack, no core_final.
  - init clears err and pulses core_init once.
- init asserted mid-block (after 7 words):
  - wcnt resets; the next 16 words form a complete block with the first new word in [255:240].
- rst_n=0 during OUT:
  - Next cycle ack=0, odata=0, err=0.
  - A subsequent fetch issues core_final again rather than returning the stale digest.
